// File: rtl/regfile_mp.sv
// Multi-port register file: two combinational read ports, one write port, sequenced post-reset clear, busy scoreboard.
// Latency: reads and busy lookups are zero-latency; writes land on the next clk edge; no backpressure, Ready gates use.
module regfile_mp #(
  parameter int N        = 8,
  parameter int DEPTH    = 4,
  parameter bit ZERO_REG = 1'b1,
  parameter bit BYPASS   = 1'b1,
  localparam int AW      = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          nReset,
  input  logic          Reg_w,
  input  logic [AW-1:0] Waddr,
  input  logic [N-1:0]  Wdata,
  input  logic [AW-1:0] Raddr1,
  input  logic [AW-1:0] Raddr2,
  output logic [N-1:0]  Rdata1,
  output logic [N-1:0]  Rdata2,
  input  logic          Busy_set,
  input  logic [AW-1:0] Busy_addr,
  output logic          Busy1,
  output logic          Busy2,
  output logic          Ready
);

  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t          state;
  state_t          state_nxt;
  logic [AW-1:0]   cnt;
  logic [AW-1:0]   cnt_nxt;
  logic            running;

  logic [N-1:0]    gpr [DEPTH];
  logic [DEPTH-1:0] busy;
  logic [DEPTH-1:0] busy_nxt;

  logic            wr_en;
  logic [AW-1:0]   wr_addr;
  logic [N-1:0]    wr_dat;

  logic [AW-1:0]   raddr [2];
  logic [N-1:0]    rdata [2];
  logic            rbusy [2];

  // State register
  always_ff @(posedge clk) begin
    if (!nReset) begin
      state <= INIT;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Next-state logic: INIT walks every address once, then hands over to RUN
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      INIT: begin
        cnt_nxt = cnt + AW'(1);
        if (cnt == AW'(DEPTH - 1)) begin
          state_nxt = RUN;
        end
      end
      RUN: begin
        state_nxt = RUN;
      end
      default: begin
        state_nxt = INIT;
        cnt_nxt   = '0;
      end
    endcase
  end

  // Output logic
  always_comb begin
    running = (state == RUN);
    Ready   = running;
  end

  // Single write port shared between the clear sequencer and normal writeback
  always_comb begin
    wr_en   = 1'b0;
    wr_addr = Waddr;
    wr_dat  = Wdata;
    if (!running) begin
      wr_en   = 1'b1;
      wr_addr = cnt;
      wr_dat  = '0;
    end else if (Reg_w && !(ZERO_REG && (Waddr == '0))) begin
      wr_en   = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (nReset && wr_en) begin
      gpr[wr_addr] <= wr_dat;
    end
  end

  // Scoreboard: a newly issued producer outranks a retiring one on the same register
  always_comb begin
    busy_nxt = busy;
    if (running) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (Busy_set && (Busy_addr == AW'(i)) && !(ZERO_REG && (i == 0))) begin
          busy_nxt[i] = 1'b1;
        end else if (Reg_w && (Waddr == AW'(i))) begin
          busy_nxt[i] = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!nReset) begin
      busy <= '0;
    end else begin
      busy <= busy_nxt;
    end
  end

  assign raddr[0] = Raddr1;
  assign raddr[1] = Raddr2;

  always_comb begin
    for (int p = 0; p < 2; p++) begin
      rdata[p] = '0;
      rbusy[p] = 1'b0;
      if (running) begin
        if (ZERO_REG && (raddr[p] == '0)) begin
          rdata[p] = '0;
        end else if (BYPASS && Reg_w && (Waddr == raddr[p])) begin
          rdata[p] = Wdata;
        end else begin
          rdata[p] = gpr[raddr[p]];
        end
        // A write retiring this register hides its busy bit unless a new producer is issued alongside
        if (BYPASS && Reg_w && (Waddr == raddr[p]) && !(Busy_set && (Busy_addr == raddr[p]))) begin
          rbusy[p] = 1'b0;
        end else begin
          rbusy[p] = busy[raddr[p]];
        end
      end
    end
  end

  assign Rdata1 = rdata[0];
  assign Rdata2 = rdata[1];
  assign Busy1  = rbusy[0];
  assign Busy2  = rbusy[1];

endmodule

// File: tb/tb_regfile_mp.sv
// Bench for regfile_mp: two instances (zero-reg+bypass, plain) driven in lockstep against an array model.
module tb_regfile_mp;
  localparam int N     = 16;
  localparam int DEPTH = 8;
  localparam int AW    = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          nReset;
  logic          Reg_w;
  logic [AW-1:0] Waddr;
  logic [N-1:0]  Wdata;
  logic [AW-1:0] Raddr1;
  logic [AW-1:0] Raddr2;
  logic          Busy_set;
  logic [AW-1:0] Busy_addr;

  logic [N-1:0]  rd1_a, rd2_a, rd1_b, rd2_b;
  logic          bz1_a, bz2_a, bz1_b, bz2_b;
  logic          rdy_a, rdy_b;

  int tests = 0;
  int fails = 0;

  regfile_mp #(.N(N), .DEPTH(DEPTH), .ZERO_REG(1'b1), .BYPASS(1'b1)) u_a (
    .clk(clk), .nReset(nReset), .Reg_w(Reg_w), .Waddr(Waddr), .Wdata(Wdata),
    .Raddr1(Raddr1), .Raddr2(Raddr2), .Rdata1(rd1_a), .Rdata2(rd2_a),
    .Busy_set(Busy_set), .Busy_addr(Busy_addr), .Busy1(bz1_a), .Busy2(bz2_a),
    .Ready(rdy_a)
  );

  regfile_mp #(.N(N), .DEPTH(DEPTH), .ZERO_REG(1'b0), .BYPASS(1'b0)) u_b (
    .clk(clk), .nReset(nReset), .Reg_w(Reg_w), .Waddr(Waddr), .Wdata(Wdata),
    .Raddr1(Raddr1), .Raddr2(Raddr2), .Rdata1(rd1_b), .Rdata2(rd2_b),
    .Busy_set(Busy_set), .Busy_addr(Busy_addr), .Busy1(bz1_b), .Busy2(bz2_b),
    .Ready(rdy_b)
  );

  // Reference model: index 0 = u_a, index 1 = u_b
  logic [N-1:0] mg [2][DEPTH];
  bit           mb [2][DEPTH];
  bit           zr [2] = '{1'b1, 1'b0};
  bit           bp [2] = '{1'b1, 1'b0};
  int           init_left = DEPTH;
  bit           known = 1'b0;

  function automatic logic [N-1:0] exp_rd(input int k, input logic [AW-1:0] ra);
    if (init_left != 0) return '0;
    if (zr[k] && ra == 0) return '0;
    if (bp[k] && Reg_w && Waddr == ra) return Wdata;
    return mg[k][ra];
  endfunction

  function automatic logic exp_bz(input int k, input logic [AW-1:0] ra);
    if (init_left != 0) return 1'b0;
    if (bp[k] && Reg_w && Waddr == ra && !(Busy_set && Busy_addr == ra)) return 1'b0;
    return mb[k][ra];
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_edge();
    if (!nReset) begin
      init_left = DEPTH;
      known = 1'b1;
      for (int k = 0; k < 2; k++)
        for (int i = 0; i < DEPTH; i++) mb[k][i] = 1'b0;
    end else if (known && init_left > 0) begin
      init_left--;
      if (init_left == 0)
        for (int k = 0; k < 2; k++)
          for (int i = 0; i < DEPTH; i++) mg[k][i] = '0;
    end else if (known) begin
      for (int k = 0; k < 2; k++) begin
        if (Reg_w && !(zr[k] && Waddr == 0)) mg[k][Waddr] = Wdata;
        if (Reg_w) mb[k][Waddr] = 1'b0;
        if (Busy_set && !(zr[k] && Busy_addr == 0)) mb[k][Busy_addr] = 1'b1;
      end
    end
  endtask

  // Called just after a falling edge with inputs set: check outputs, take one rising edge
  task step();
    #1;
    if (known) begin
      chk("rdata1_a", rd1_a, exp_rd(0, Raddr1));
      chk("rdata2_a", rd2_a, exp_rd(0, Raddr2));
      chk("busy1_a", bz1_a, exp_bz(0, Raddr1));
      chk("busy2_a", bz2_a, exp_bz(0, Raddr2));
      chk("ready_a", rdy_a, init_left == 0);
      chk("rdata1_b", rd1_b, exp_rd(1, Raddr1));
      chk("rdata2_b", rd2_b, exp_rd(1, Raddr2));
      chk("busy1_b", bz1_b, exp_bz(1, Raddr1));
      chk("busy2_b", bz2_b, exp_bz(1, Raddr2));
      chk("ready_b", rdy_b, init_left == 0);
    end
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  initial begin
    nReset = 1'b0; Reg_w = 1'b0; Waddr = '0; Wdata = '0;
    Raddr1 = '0; Raddr2 = '0; Busy_set = 1'b0; Busy_addr = '0;
    @(negedge clk);

    // Reset held two cycles, then the clear sequence with a write attempt in flight
    step(); step();
    nReset = 1'b1; Reg_w = 1'b1; Waddr = 3'd5; Wdata = 16'hBEEF;
    Busy_set = 1'b1; Busy_addr = 3'd5; Raddr1 = 3'd5; Raddr2 = 3'd5;
    for (int c = 1; c <= DEPTH; c++) begin
      #1 chk("init_ready_low", rdy_a, 1'b0);
      chk("init_rdata_zero", rd1_a, 16'h0000);
      step();
    end
    Reg_w = 1'b0; Busy_set = 1'b0;
    #1 chk("ready_cycle9", rdy_a, 1'b1);
    chk("init_write_ignored", rd1_b, 16'h0000);
    chk("init_busy_ignored", bz1_b, 1'b0);
    step();

    // Write / read, zero register
    Reg_w = 1'b1; Waddr = 3'd2; Wdata = 16'h00A5; step();
    Reg_w = 1'b0; Raddr1 = 3'd2;
    #1 chk("r2_a", rd1_a, 16'h00A5);
    chk("r2_b", rd1_b, 16'h00A5);
    Reg_w = 1'b1; Waddr = 3'd0; Wdata = 16'h003C; step();
    Reg_w = 1'b0; Raddr2 = 3'd0;
    #1 chk("r0_zero_a", rd2_a, 16'h0000);
    chk("r0_plain_b", rd2_b, 16'h003C);
    step();

    // Bypass vs. registered read
    Reg_w = 1'b1; Waddr = 3'd3; Wdata = 16'h00A5; step();
    Wdata = 16'h0077; Raddr1 = 3'd3; Raddr2 = 3'd3;
    #1 chk("bypass1_a", rd1_a, 16'h0077);
    chk("bypass2_a", rd2_a, 16'h0077);
    chk("nobypass1_b", rd1_b, 16'h00A5);
    chk("nobypass2_b", rd2_b, 16'h00A5);
    step();
    Reg_w = 1'b0;
    #1 chk("after_write_b", rd1_b, 16'h0077);
    step();

    // Scoreboard set, clear, and set-wins collision
    Busy_set = 1'b1; Busy_addr = 3'd5; step();
    Busy_set = 1'b0; Raddr1 = 3'd5;
    #1 chk("busy_set_a", bz1_a, 1'b1);
    chk("busy_set_b", bz1_b, 1'b1);
    Reg_w = 1'b1; Waddr = 3'd5; Wdata = 16'h0555;
    #1 chk("busy_bypass_clr_a", bz1_a, 1'b0);
    chk("busy_held_b", bz1_b, 1'b1);
    step();
    Reg_w = 1'b0;
    #1 chk("busy_clr_b", bz1_b, 1'b0);
    step();
    Busy_set = 1'b1; Busy_addr = 3'd5; Reg_w = 1'b1; Waddr = 3'd5; step();
    Busy_set = 1'b0; Reg_w = 1'b0;
    #1 chk("set_wins_a", bz1_a, 1'b1);
    chk("set_wins_b", bz1_b, 1'b1);
    step();

    // Reset during RUN
    Reg_w = 1'b1; Waddr = 3'd1; Wdata = 16'h0011; Busy_set = 1'b1; Busy_addr = 3'd1; step();
    Reg_w = 1'b0; Busy_set = 1'b0; Raddr1 = 3'd1;
    #1 chk("r1_before_rst", rd1_a, 16'h0011);
    chk("busy1_before_rst", bz1_a, 1'b1);
    nReset = 1'b0; step();
    nReset = 1'b1;
    #1 chk("rst_ready", rdy_a, 1'b0);
    chk("rst_busy", bz1_a, 1'b0);
    chk("rst_rdata", rd1_b, 16'h0000);
    for (int c = 1; c <= DEPTH; c++) step();
    #1 chk("rst_ready_back", rdy_b, 1'b1);
    chk("r1_cleared", rd1_b, 16'h0000);
    step();

    // Reset during INIT restarts the clear
    nReset = 1'b0; step();
    nReset = 1'b1; step(); step(); step();
    nReset = 1'b0; step();
    nReset = 1'b1;
    for (int c = 1; c <= DEPTH; c++) begin
      #1 chk("reinit_ready_low", rdy_a, 1'b0);
      step();
    end
    #1 chk("reinit_ready_high", rdy_a, 1'b1);
    step();

    // Randomised traffic with occasional resets
    for (int n = 0; n < 800; n++) begin
      nReset    = ($urandom_range(0, 99) != 0);
      Reg_w     = $urandom_range(0, 1) == 1;
      Waddr     = AW'($urandom);
      Wdata     = N'($urandom);
      Raddr1    = AW'($urandom);
      Raddr2    = ($urandom_range(0, 3) == 0) ? Waddr : AW'($urandom);
      Busy_set  = $urandom_range(0, 2) == 0;
      Busy_addr = ($urandom_range(0, 3) == 0) ? Waddr : AW'($urandom);
      step();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
